// File: rtl/mem_arbiter_top_if.sv
// Bus bundle between the two cache requesters, the RAM port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_top_if;
  logic [31:0] icache_raddr_i;
  logic        icache_raddr_valid_i;
  logic [7:0]  icache_rmask_i;
  logic        icache_rdata_ready_o;
  logic [63:0] icache_rdata_o;

  logic [31:0] ram_raddr_dcache_i;
  logic        ram_raddr_valid_dcache_i;
  logic [7:0]  ram_rmask_dcache_i;
  logic [31:0] ram_waddr_dcache_i;
  logic        ram_waddr_valid_dcache_i;
  logic [7:0]  ram_wmask_dcache_i;
  logic [63:0] ram_wdata_dcache_i;
  logic        ram_rdata_ready_dcache_o;
  logic        ram_wdata_ready_dcache_o;
  logic [63:0] ram_rdata_dcache_o;

  logic [31:0] ram_addr_o;
  logic        ram_valid_o;
  logic        ram_we_o;
  logic [7:0]  ram_mask_o;
  logic [63:0] ram_wdata_o;
  logic        ram_ready_i;
  logic [63:0] ram_rdata_i;

  modport slave (
    input  icache_raddr_i, icache_raddr_valid_i, icache_rmask_i,
    output icache_rdata_ready_o, icache_rdata_o,
    input  ram_raddr_dcache_i, ram_raddr_valid_dcache_i, ram_rmask_dcache_i,
    input  ram_waddr_dcache_i, ram_waddr_valid_dcache_i, ram_wmask_dcache_i,
    input  ram_wdata_dcache_i,
    output ram_rdata_ready_dcache_o, ram_wdata_ready_dcache_o, ram_rdata_dcache_o,
    output ram_addr_o, ram_valid_o, ram_we_o, ram_mask_o, ram_wdata_o,
    input  ram_ready_i, ram_rdata_i
  );

  modport master (
    output icache_raddr_i, icache_raddr_valid_i, icache_rmask_i,
    input  icache_rdata_ready_o, icache_rdata_o,
    output ram_raddr_dcache_i, ram_raddr_valid_dcache_i, ram_rmask_dcache_i,
    output ram_waddr_dcache_i, ram_waddr_valid_dcache_i, ram_wmask_dcache_i,
    output ram_wdata_dcache_i,
    input  ram_rdata_ready_dcache_o, ram_wdata_ready_dcache_o, ram_rdata_dcache_o,
    input  ram_addr_o, ram_valid_o, ram_we_o, ram_mask_o, ram_wdata_o,
    output ram_ready_i, ram_rdata_i
  );
endinterface

// File: rtl/mem_arbiter_top.sv
// Round-robin arbiter sharing one RAM port between icache reads and dcache reads/writes,
// one transaction at a time, with a sticky watchdog on transactions that never complete.
module mem_arbiter_top #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_arbiter_top_if.slave       bus,
  output logic                   err_timeout_o
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantDr, StGrantDw} state_e;

  localparam logic [10:0] TimeoutLim = 11'(TIMEOUT_CYCLES);

  state_e     r_state;
  logic       r_rr_last;  // 1 = dcache was granted last
  logic [9:0] r_cnt;
  logic       r_err;
  logic       w_d_req;
  logic       w_d_write;

  assign w_d_req   = bus.ram_raddr_valid_dcache_i | bus.ram_waddr_valid_dcache_i;
  assign w_d_write = bus.ram_waddr_valid_dcache_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_rr_last <= 1'b1;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else if (r_state == StIdle) begin
      r_cnt <= '0;
      if (bus.icache_raddr_valid_i && (!w_d_req || r_rr_last)) begin
        r_state <= StGrantI;
      end else if (w_d_req) begin
        r_state <= w_d_write ? StGrantDw : StGrantDr;
      end
    end else if (bus.ram_ready_i) begin
      r_state   <= StIdle;
      r_rr_last <= (r_state != StGrantI);
    end else begin
      if (r_cnt != 10'h3FF) begin
        r_cnt <= r_cnt + 10'd1;
      end
      // Count includes the cycle just ending, so err shows after TIMEOUT_CYCLES busy cycles
      if (({1'b0, r_cnt} + 11'd1) >= TimeoutLim) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.ram_valid_o              = 1'b0;
    bus.ram_we_o                 = 1'b0;
    bus.ram_addr_o               = '0;
    bus.ram_mask_o               = '0;
    bus.ram_wdata_o              = '0;
    bus.icache_rdata_ready_o     = 1'b0;
    bus.ram_rdata_ready_dcache_o = 1'b0;
    bus.ram_wdata_ready_dcache_o = 1'b0;
    unique case (r_state)
      StGrantI: begin
        bus.ram_valid_o          = 1'b1;
        bus.ram_addr_o           = bus.icache_raddr_i;
        bus.ram_mask_o           = bus.icache_rmask_i;
        bus.icache_rdata_ready_o = bus.ram_ready_i;
      end
      StGrantDr: begin
        bus.ram_valid_o              = 1'b1;
        bus.ram_addr_o               = bus.ram_raddr_dcache_i;
        bus.ram_mask_o               = bus.ram_rmask_dcache_i;
        bus.ram_rdata_ready_dcache_o = bus.ram_ready_i;
      end
      StGrantDw: begin
        bus.ram_valid_o              = 1'b1;
        bus.ram_we_o                 = 1'b1;
        bus.ram_addr_o               = bus.ram_waddr_dcache_i;
        bus.ram_mask_o               = bus.ram_wmask_dcache_i;
        bus.ram_wdata_o              = bus.ram_wdata_dcache_i;
        bus.ram_wdata_ready_dcache_o = bus.ram_ready_i;
      end
      default: ;
    endcase
  end

  assign bus.icache_rdata_o     = bus.ram_rdata_i;
  assign bus.ram_rdata_dcache_o = bus.ram_rdata_i;
  assign err_timeout_o          = r_err;

endmodule

// File: tb/tb_mem_arbiter_top.sv
// Directed bench for mem_arbiter_top: per-cycle vector table plus hand sequences for
// watchdog and asynchronous reset.
module tb_mem_arbiter_top;

  localparam logic [31:0] AI = 32'h8000_0000;
  localparam logic [31:0] AD = 32'h8000_0100;
  localparam logic [31:0] AW = 32'h8000_0010;
  localparam logic [63:0] R1 = 64'h1122_3344_5566_7788;
  localparam logic [7:0]  IMask = 8'hFF;
  localparam logic [7:0]  DRMask = 8'h3C;

  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        drv;
    logic [31:0] dra;
    logic        dwv;
    logic [31:0] dwa;
    logic [7:0]  dwm;
    logic [63:0] dwd;
    logic        rdy;
    logic [63:0] rd;
    logic [1:0]  owner;  // 0 idle, 1 I, 2 D read, 3 D write
    logic        eir;
    logic        edr;
    logic        edw;
  } vec_t;

  logic clk;
  logic rst;
  logic err_timeout;
  int   n_pass;
  int   n_total;
  vec_t vq[$];

  mem_arbiter_top_if bus ();

  mem_arbiter_top #(.TIMEOUT_CYCLES(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .err_timeout_o (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic r, logic iv, logic [31:0] ia, logic drv, logic [31:0] dra,
                              logic dwv, logic [31:0] dwa, logic [7:0] dwm, logic [63:0] dwd,
                              logic rdy, logic [63:0] rd, logic [1:0] owner,
                              logic eir, logic edr, logic edw);
    vec_t v;
    v.rst = r; v.iv = iv; v.ia = ia; v.drv = drv; v.dra = dra;
    v.dwv = dwv; v.dwa = dwa; v.dwm = dwm; v.dwd = dwd; v.rdy = rdy; v.rd = rd;
    v.owner = owner; v.eir = eir; v.edr = edr; v.edw = edw;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic drv,
                       input logic [31:0] dra, input logic dwv, input logic [31:0] dwa,
                       input logic [7:0] dwm, input logic [63:0] dwd, input logic rdy,
                       input logic [63:0] rd);
    bus.icache_raddr_valid_i     = iv;
    bus.icache_raddr_i           = ia;
    bus.icache_rmask_i           = IMask;
    bus.ram_raddr_valid_dcache_i = drv;
    bus.ram_raddr_dcache_i       = dra;
    bus.ram_rmask_dcache_i       = DRMask;
    bus.ram_waddr_valid_dcache_i = dwv;
    bus.ram_waddr_dcache_i       = dwa;
    bus.ram_wmask_dcache_i       = dwm;
    bus.ram_wdata_dcache_i       = dwd;
    bus.ram_ready_i              = rdy;
    bus.ram_rdata_i              = rd;
  endtask

  // Expected RAM-side fields follow from which requester should own the port this cycle.
  task automatic check_row(input string name, input logic [1:0] owner, input logic eir,
                           input logic edr, input logic edw, input logic eerr);
    logic        ev, ewe;
    logic [31:0] ea;
    logic [7:0]  em;
    logic [63:0] ewd, awd;
    ev = 1'b0; ewe = 1'b0; ea = '0; em = '0; ewd = '0;
    case (owner)
      2'd1: begin ev = 1'b1; ea = bus.icache_raddr_i; em = IMask; end
      2'd2: begin ev = 1'b1; ea = bus.ram_raddr_dcache_i; em = DRMask; end
      2'd3: begin
        ev = 1'b1; ewe = 1'b1; ea = bus.ram_waddr_dcache_i;
        em = bus.ram_wmask_dcache_i; ewd = bus.ram_wdata_dcache_i;
      end
      default: ;
    endcase
    // Write data is unspecified during reads
    awd = (owner == 2'd1 || owner == 2'd2) ? 64'd0 : bus.ram_wdata_o;
    check(name,
          {18'd0, bus.ram_valid_o, bus.ram_we_o, bus.ram_addr_o, bus.ram_mask_o, awd,
           bus.icache_rdata_ready_o, bus.ram_rdata_ready_dcache_o,
           bus.ram_wdata_ready_dcache_o, err_timeout},
          {18'd0, ev, ewe, ea, em, ewd, eir, edr, edw, eerr});
    check({name, "/rdata"}, {bus.icache_rdata_o, bus.ram_rdata_dcache_o},
          {bus.ram_rdata_i, bus.ram_rdata_i});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    drive(0, '0, 0, '0, 0, '0, '0, '0, 1, 64'h5A5A);
    #1;
    check_row("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // single icache read, ready ignored in idle, dcache write
    vq.push_back(mk(0, 1, AI, 0, '0, 0, '0, '0, '0, 0, 64'h1, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 0, '0, 0, '0, '0, '0, 0, 64'h2, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 0, '0, 0, '0, '0, '0, 0, 64'h3, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 0, '0, 0, '0, '0, '0, 1, R1, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, AI, 0, '0, 0, '0, '0, '0, 0, 64'h4, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, AI, 0, '0, 0, '0, '0, '0, 1, 64'h5, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, '0, 0, '0, 1, AW, 8'h0F, 64'hDEADBEEF, 0, 64'h6, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, '0, 0, '0, 1, AW, 8'h0F, 64'hDEADBEEF, 0, 64'h7, 3, 0, 0, 0));
    vq.push_back(mk(0, 0, '0, 0, '0, 1, AW, 8'h0F, 64'hDEADBEEF, 1, 64'h8, 3, 0, 0, 1));
    vq.push_back(mk(0, 0, '0, 0, '0, 0, '0, '0, '0, 0, 64'h9, 0, 0, 0, 0));
    // I and D both held from reset: I, D, I, D with an idle cycle between
    vq.push_back(mk(1, 1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h10, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 1, 64'h11, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h12, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 1, 64'h13, 2, 0, 1, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h14, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h15, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 1, 64'h16, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h17, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, AI, 1, AD, 0, '0, '0, '0, 1, 64'h18, 2, 0, 1, 0));
    vq.push_back(mk(0, 0, AI, 0, AD, 0, '0, '0, '0, 0, 64'h19, 0, 0, 0, 0));
    // both dcache valids: write wins
    vq.push_back(mk(0, 0, '0, 1, AD, 1, 32'h8000_0020, 8'hF0, 64'hCAFE, 0, 64'h20, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, '0, 1, AD, 1, 32'h8000_0020, 8'hF0, 64'hCAFE, 1, 64'h21, 3, 0, 0, 1));
    vq.push_back(mk(0, 0, '0, 0, AD, 0, '0, '0, '0, 0, 64'h22, 0, 0, 0, 0));
    // two-beat dcache fill with icache granted between beats
    vq.push_back(mk(0, 0, '0, 1, 32'h8000_0200, 0, '0, '0, '0, 0, 64'h30, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_0300, 1, 32'h8000_0200, 0, '0, '0, '0, 1, 64'hA1, 2, 0, 1, 0));
    vq.push_back(mk(0, 1, 32'h8000_0300, 1, 32'h8000_0208, 0, '0, '0, '0, 0, 64'h31, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_0300, 1, 32'h8000_0208, 0, '0, '0, '0, 1, 64'hB2, 1, 1, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_0300, 1, 32'h8000_0208, 0, '0, '0, '0, 0, 64'h32, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 32'h8000_0300, 1, 32'h8000_0208, 0, '0, '0, '0, 0, 64'h33, 2, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h8000_0300, 1, 32'h8000_0208, 0, '0, '0, '0, 1, 64'hC3, 2, 0, 1, 0));
    vq.push_back(mk(0, 0, '0, 0, '0, 0, '0, '0, '0, 0, 64'h34, 0, 0, 0, 0));
    // owner drops valid while granted: grant held, ready still routed
    vq.push_back(mk(0, 1, 32'h8000_0400, 0, '0, 0, '0, '0, '0, 0, 64'h40, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h8000_0400, 0, '0, 0, '0, '0, '0, 0, 64'h41, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 32'h8000_0400, 0, '0, 0, '0, '0, '0, 1, 64'h42, 1, 1, 0, 0));
    vq.push_back(mk(0, 0, '0, 0, '0, 0, '0, '0, '0, 0, 64'h43, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      if (vq[i].rst) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      drive(vq[i].iv, vq[i].ia, vq[i].drv, vq[i].dra, vq[i].dwv, vq[i].dwa, vq[i].dwm,
            vq[i].dwd, vq[i].rdy, vq[i].rd);
      #1;
      check_row($sformatf("row%0d", i), vq[i].owner, vq[i].eir, vq[i].edr, vq[i].edw, 1'b0);
    end

    // watchdog: RAM stalls, error after 5 busy cycles, late ready still completes
    @(negedge clk);
    drive(1, 32'h8000_0500, 0, '0, 0, '0, '0, '0, 0, 64'h50);
    #1;
    check_row("tmo0", 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(1, 32'h8000_0500, 0, '0, 0, '0, '0, '0, 0, 64'h50 + 64'(k));
      #1;
      check_row($sformatf("tmo%0d", k), 1, 0, 0, 0, k == 6);
    end
    @(negedge clk);
    drive(1, 32'h8000_0500, 0, '0, 0, '0, '0, '0, 1, 64'h57);
    #1;
    check_row("tmo_late", 1, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, '0, 0, '0, 0, '0, '0, '0, 0, 64'h58);
    #1;
    check_row("tmo_sticky", 0, 0, 0, 0, 1);

    // asynchronous reset in the middle of a dcache write grant
    @(negedge clk);
    drive(0, '0, 0, '0, 1, 32'h8000_0030, 8'h33, 64'h0123_4567_89AB_CDEF, 0, 64'h60);
    #1;
    check_row("arst_idle", 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    check_row("arst_dw", 3, 0, 0, 0, 1);
    #2;
    rst = 1'b0;
    #1;
    check_row("arst_now", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, AI, 1, AD, 0, '0, '0, '0, 0, 64'h61);
    #1;
    check_row("arst_rel", 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_row("arst_tie_i", 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, AI, 1, AD, 0, '0, '0, '0, 1, 64'h62);
    #1;
    check_row("arst_done", 1, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, '0, 0, '0, 0, '0, '0, '0, 0, 64'h63);
    #1;
    check_row("arst_end", 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_top.md
# mem_arbiter_top

Two-master, one-slave arbiter that shares the single RAM port between the instruction cache (read-only) and the data cache (read and write). It sits between `icache_top`/`dcache_top` and the RAM model or AXI bridge. Requests are granted round-robin, one transaction at a time, and the grant is held until the RAM signals ready. A watchdog flags a RAM transaction that never completes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: BUSY cycles without `ram_ready_i` before `err_timeout_o` sets. Range 1..1023.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `icache_raddr_i`  in  `NPC_ADDR_BUS` (32)  icache read address.
- `icache_raddr_valid_i`  in  1  icache read request.
- `icache_rmask_i`  in  8  icache byte mask.
- `icache_rdata_ready_o`  out  1  one-cycle completion pulse to icache.
- `icache_rdata_o`  out  `XLEN_BUS` (64)  read data, `ram_rdata_i` passthrough.
- `ram_raddr_dcache_i`, `ram_raddr_valid_dcache_i`, `ram_rmask_dcache_i`  in  32/1/8  dcache read request.
- `ram_waddr_dcache_i`, `ram_waddr_valid_dcache_i`, `ram_wmask_dcache_i`, `ram_wdata_dcache_i`  in  32/1/8/64  dcache write request.
- `ram_rdata_ready_dcache_o`  out  1  dcache read completion pulse.
- `ram_wdata_ready_dcache_o`  out  1  dcache write completion pulse.
- `ram_rdata_dcache_o`  out  64  read data, `ram_rdata_i` passthrough.
- `ram_addr_o`  out  32  address to RAM.
- `ram_valid_o`  out  1  request valid to RAM.
- `ram_we_o`  out  1  1 = write, 0 = read.
- `ram_mask_o`  out  8  byte mask.
- `ram_wdata_o`  out  64  write data.
- `ram_ready_i`  in  1  RAM completion pulse; read data is valid in the same cycle.
- `ram_rdata_i`  in  64  RAM read data.
- `err_timeout_o`  out  1  sticky watchdog error.

## Operation
- Requesters:
  - I = icache read.
  - D = dcache. D selects write if `ram_waddr_valid_dcache_i` is high, otherwise read.
  - If both dcache valids are high at once, that is a protocol violation; write wins.
- Registered state:
  - FSM states: IDLE, GRANT_I, GRANT_DR, GRANT_DW.
  - `rr_last` (1 bit): last requester granted.
  - Timeout counter (10 bits).
- IDLE behaviour:
  - Only I valid: go to GRANT_I.
  - Only D valid: go to GRANT_DR or GRANT_DW.
  - Both valid: grant the requester that is not `rr_last`.
  - Neither valid: stay in IDLE.
  - In IDLE, `ram_valid_o` = 0 and all ready outputs = 0.
- GRANT_x behaviour:
  - `ram_addr_o`, `ram_mask_o`, `ram_wdata_o` and `ram_we_o` are combinationally muxed from the owner's current inputs.
  - `ram_valid_o` = 1.
  - Owner changes its address while granted (dcache second fill beat): the new address is forwarded. Requesters must hold their request stable until their ready pulse.
- Completion:
  - On `ram_ready_i` = 1 in GRANT_x, the owner's ready output = 1 in that same cycle and no other ready output is asserted.
  - Next state is IDLE, and `rr_last` is updated to the owner.
- Owner valid dropping while granted is a protocol violation. The grant is held anyway, the transaction completes, and the ready pulse is still routed to the owner.
- Read data: both `icache_rdata_o` and `ram_rdata_dcache_o` always equal `ram_rdata_i`. Consumers qualify the data with their own ready pulse.
- `ram_ready_i` in IDLE is ignored and has no effect on state or outputs.
- Watchdog:
  - The counter clears on entry to GRANT_x and increments each GRANT_x cycle without ready, saturating at 1023.
  - When the count reaches `TIMEOUT_CYCLES`, `err_timeout_o` sets and stays set until reset.
  - The grant is not aborted.

## Timing
- Reset values:
  - State = IDLE; `rr_last` = D, so I wins the first tie.
  - Counter = 0; `err_timeout_o` = 0.
  - `ram_valid_o`, `ram_we_o` and all ready outputs = 0.
  - `ram_addr_o`, `ram_mask_o` and `ram_wdata_o` = 0 in IDLE.
- Reset asserted mid-transaction: outputs drop immediately (asynchronous). The RAM must discard the request.
- Latency:
  - Valid seen in IDLE at cycle N: `ram_valid_o` = 1 at cycle N+1.
  - Zero-wait RAM (ready in cycle N+1): owner ready also in cycle N+1.
- Minimum one IDLE cycle between transactions; `ram_valid_o` is low for at least 1 cycle between grants.
- Back-to-back requester: peak throughput is 1 transaction per 2 cycles.
- Ready outputs are strictly one-cycle pulses, combinational from `ram_ready_i` gated by the state.

## Test plan
- Single icache read, addr 0x8000_0000, RAM ready after 3 cycles, rdata 0x1122334455667788 -> `ram_valid_o` high cycles 1-3, `icache_rdata_ready_o` pulses in cycle 3 with that data; state back to IDLE in cycle 4.
- I and D read both valid from reset and held -> grant order I, D, I, D. Each completion is followed by one IDLE cycle; no ready pulse reaches the non-owner.
- dcache write 0x8000_0010, mask 0x0F, wdata 0xDEADBEEF -> `ram_we_o` = 1, `ram_mask_o` = 0x0F, `ram_wdata_o` = 0xDEADBEEF; only `ram_wdata_ready_dcache_o` pulses.
- dcache two-beat fill: second address 0x...8 presented after the first ready, icache also pending -> I is granted between the beats, then D completes 0x...8; both receive correct data.
- `TIMEOUT_CYCLES` = 5, RAM never readies -> `err_timeout_o` rises after 5 BUSY cycles, `ram_valid_o` stays 1. A late ready then completes the transaction and `err_timeout_o` stays 1.
- `rst` = 0 asserted mid-GRANT_DW, at a time no clock edge occurs -> `ram_valid_o` = 0 immediately. After release, state is IDLE and `rr_last` = D.
